inst_mem_responder: RTL and testbench

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

---
 rtl/processor_pkg.sv | 12 +
 rtl/system_pkg.sv | 20 ++
 rtl/imem_array.sv | 36 +++
 rtl/inst_mem_responder.sv | 123 ++++++++++++
 tb/tb_inst_mem_responder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/processor_pkg.sv
// Processor-side enums: fetch responder state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package Processor_Pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

endpackage

// File: rtl/system_pkg.sv
// Shared memory-port types: fetch request/response structs and the NOP word.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package System_Pkg;

    typedef struct packed {
        logic        Req;
        logic [31:0] Address;
    } Mem_Req;

    typedef struct packed {
        logic        Ready;
        logic [31:0] Inst;
        logic        Error;
    } Mem_Respond;

    // Returned in place of the fetched word when a slot is rejected.
    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// Instruction backing store: one write port, two registered read ports.
// Latency: read data valid the cycle after rd_en; write takes effect at the edge.
// Backpressure: none; always accepts reads and writes.
//
// Ports: core_clk; wr_en/wr_idx/wr_dat write port; rd_en with rd_idx1/rd_idx2
// selects two words captured into rd_dat1/rd_dat2. A read of a word written at
// the same edge returns the old contents. Contents are never reset.
// DEPTH must be a power of two, at least 2.
module imem_array #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          core_clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx1,
    input  logic [AW-1:0] rd_idx2,
    output logic [31:0]   rd_dat1,
    output logic [31:0]   rd_dat2
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge core_clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat1 <= mem[rd_idx1];
            rd_dat2 <= mem[rd_idx2];
        end
    end

endmodule

// File: rtl/inst_mem_responder.sv
// Two-slot instruction fetch responder over a preloadable word array.
// Latency: Ready pulses for one cycle LATENCY cycles after the accepting edge.
// Backpressure: Busy high while a fetch is in flight; requests then are dropped.
//
// Ports: Clk, Rst (async active-low); Inst1_Req/Inst2_Req fetch request and
// slot-1 address override; Inst1_Resp/Inst2_Resp responses (Inst/Error are 0
// unless Ready); Load_We/Load_Addr/Load_Data preload write port; Busy.
// Build option: define IMEM_ALIGN_CHECK_EN to flag misaligned slot addresses
// with Error=1 and a NOP instruction; otherwise Address[1:0] is ignored.
module inst_mem_responder
    import System_Pkg::*;
    import Processor_Pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  Mem_Req      Inst1_Req,
    input  Mem_Req      Inst2_Req,
    output Mem_Respond  Inst1_Resp,
    output Mem_Respond  Inst2_Resp,
    input  logic        Load_We,
    input  logic [31:0] Load_Addr,
    input  logic [31:0] Load_Data,
    output logic        Busy
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    imem_state_e state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [31:0] a1, a2, a1_d, a2_d;
    logic        rd_en;
    logic [31:0] rd_dat1, rd_dat2;
    logic        resp_vld;
    logic        mis1, mis2;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        a1_d    = a1;
        a2_d    = a2;
        case (state)
            IDLE: begin
                if (Inst1_Req.Req) begin
                    a1_d    = Inst1_Req.Address;
                    a2_d    = Inst2_Req.Req ? Inst2_Req.Address
                                            : Inst1_Req.Address + 32'd4;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // Leave when the count reaches zero on this edge.
                cnt_d = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Words are sampled on the edge that enters RESP; a1_d/a2_d already
        // hold the live request addresses when LATENCY=1 skips WAIT.
        rd_en = (state_d == RESP);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            a1    <= 32'd0;
            a2    <= 32'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            a1    <= a1_d;
            a2    <= a2_d;
        end
    end

    imem_array #(.DEPTH(DEPTH)) u_array (
        .core_clk (Clk),
        .wr_en    (Load_We),
        .wr_idx   (Load_Addr[AW+1:2]),
        .wr_dat   (Load_Data),
        .rd_en    (rd_en),
        .rd_idx1  (a1_d[AW+1:2]),
        .rd_idx2  (a2_d[AW+1:2]),
        .rd_dat1  (rd_dat1),
        .rd_dat2  (rd_dat2)
    );

`ifdef IMEM_ALIGN_CHECK_EN
    assign mis1 = (a1[1:0] != 2'b00);
    assign mis2 = (a2[1:0] != 2'b00);
`else
    assign mis1 = 1'b0;
    assign mis2 = 1'b0;
`endif

    // Word index wraps modulo DEPTH, so upper address bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{a1_d[31:AW+2], a1_d[1:0], a2_d[31:AW+2], a2_d[1:0],
                                Load_Addr[31:AW+2], Load_Addr[1:0]};

    assign resp_vld = (state == RESP);
    assign Busy     = (state != IDLE);

    always_comb begin
        Inst1_Resp       = '0;
        Inst2_Resp       = '0;
        Inst1_Resp.Ready = resp_vld;
        Inst2_Resp.Ready = resp_vld;
        Inst1_Resp.Error = resp_vld && mis1;
        Inst2_Resp.Error = resp_vld && mis2;
        Inst1_Resp.Inst  = (resp_vld && !mis1) ? rd_dat1 : NOP;
        Inst2_Resp.Inst  = (resp_vld && !mis2) ? rd_dat2 : NOP;
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: directed and random fetches, scoreboarded.
// Latency: n/a.
// Backpressure: n/a.
module tb_inst_mem_responder;
    import System_Pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
`ifdef IMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    Mem_Req      Inst1_Req, Inst2_Req;
    Mem_Respond  Inst1_Resp, Inst2_Resp;
    logic        Load_We;
    logic [31:0] Load_Addr, Load_Data;
    logic        Busy;

    always #5 Clk = ~Clk;

    inst_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Inst1_Req  (Inst1_Req),
        .Inst2_Req  (Inst2_Req),
        .Inst1_Resp (Inst1_Resp),
        .Inst2_Resp (Inst2_Resp),
        .Load_We    (Load_We),
        .Load_Addr  (Load_Addr),
        .Load_Data  (Load_Data),
        .Busy       (Busy)
    );

    typedef struct {
        int          edge_no;
        logic [31:0] inst1, inst2;
        logic        err1, err2;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e_new;
    exp_t        e_got;
    logic [31:0] mem_m [DEPTH];
    int          model_edge = 0;
    int          free_edge  = 0;
    int          busy_end   = 0;
    int          read_edge  = 0;
    bit          pend       = 1'b0;
    logic [31:0] pa1, pa2;
    int          n_checks   = 0;
    int          n_fail     = 0;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, required %h", name, model_edge, act, exp);
        end
    endtask

    // Reference model: a fetch is taken whenever the responder has been free
    // for a full cycle, words are read LATENCY-1 edges after acceptance (before
    // any same-edge preload write), and the reply is shown after that edge.
    always @(posedge Clk) begin
        model_edge++;
        if (!Rst) begin
            pend      = 1'b0;
            sb_q.delete();
            busy_end  = 0;
            free_edge = 0;
        end else begin
            if (Inst1_Req.Req && model_edge >= free_edge) begin
                pend      = 1'b1;
                pa1       = Inst1_Req.Address;
                pa2       = Inst2_Req.Req ? Inst2_Req.Address : Inst1_Req.Address + 32'd4;
                read_edge = model_edge + LAT - 1;
                busy_end  = model_edge + LAT;
                free_edge = model_edge + LAT + 1;
            end
            if (pend && model_edge == read_edge) begin
                e_new.edge_no = model_edge;
                e_new.err1    = ALIGN && (pa1[1:0] != 2'b00);
                e_new.err2    = ALIGN && (pa2[1:0] != 2'b00);
                e_new.inst1   = e_new.err1 ? 32'h0 : mem_m[widx(pa1)];
                e_new.inst2   = e_new.err2 ? 32'h0 : mem_m[widx(pa2)];
                sb_q.push_back(e_new);
                pend = 1'b0;
            end
        end
        if (Load_We) mem_m[widx(Load_Addr)] = Load_Data;
    end

    // Monitor: sampled on the falling edge, away from input changes.
    always @(negedge Clk) begin
        if (!Rst) begin
            check("reset_quiet", 32'({Inst1_Resp.Ready, Inst2_Resp.Ready, Busy}), 32'h0);
        end else begin
            automatic bit exp_rdy = (sb_q.size() > 0) && (sb_q[0].edge_no == model_edge);
            check("busy",   32'(Busy),             32'(model_edge < busy_end));
            check("ready1", 32'(Inst1_Resp.Ready), 32'(exp_rdy));
            check("ready2", 32'(Inst2_Resp.Ready), 32'(exp_rdy));
            if (exp_rdy) begin
                e_got = sb_q.pop_front();
                check("inst1", Inst1_Resp.Inst,        e_got.inst1);
                check("inst2", Inst2_Resp.Inst,        e_got.inst2);
                check("err1",  32'(Inst1_Resp.Error),  32'(e_got.err1));
                check("err2",  32'(Inst2_Resp.Error),  32'(e_got.err2));
            end else begin
                check("idle_zero", Inst1_Resp.Inst | Inst2_Resp.Inst |
                      32'({Inst1_Resp.Error, Inst2_Resp.Error}), 32'h0);
            end
        end
    end

    task automatic cyc(input bit r1, input logic [31:0] ad1, input bit r2,
                       input logic [31:0] ad2, input bit we,
                       input logic [31:0] la, input logic [31:0] ld);
        @(negedge Clk);
        #1;
        Inst1_Req.Req     = r1;
        Inst1_Req.Address = ad1;
        Inst2_Req.Req     = r2;
        Inst2_Req.Address = ad2;
        Load_We           = we;
        Load_Addr         = la;
        Load_Data         = ld;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        Rst       = 1'b0;
        Inst1_Req = '0;
        Inst2_Req = '0;
        Load_We   = 1'b0;
        Load_Addr = 32'h0;
        Load_Data = 32'h0;
        repeat (3) @(negedge Clk);
        #2;
        check("rst_busy",  32'(Busy),             32'h0);
        check("rst_ready", 32'(Inst1_Resp.Ready), 32'h0);
        check("rst_inst",  Inst1_Resp.Inst | Inst2_Resp.Inst, 32'h0);
        @(negedge Clk);
        #1;
        Rst = 1'b1;

        // Preload every word so the array holds known contents.
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'(i * 4), $urandom);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100, 32'hAAAA0001);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h104, 32'hBBBB0002);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h200, 32'hCCCC0003);
        idle(2);

        // Single fetch, implicit +4 second slot.
        cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        idle(5);
        // Explicit second-slot address.
        cyc(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
        idle(5);
        // Request held high: one fetch per LAT+1 cycles.
        repeat (12) cyc(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        idle(5);
        // Last word with the +4 slot wrapping to word 0.
        cyc(1'b1, 32'hFFC, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        idle(5);
        // Misaligned address.
        cyc(1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        idle(5);
        // Both slots on the same word.
        cyc(1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
        idle(5);

        // Asynchronous reset while the fetch waits.
        cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(posedge Clk);
        #1;
        Inst1_Req.Req = 1'b0;
        check("pre_rst_busy", 32'(Busy), 32'h1);
        #2;
        Rst = 1'b0;
        #1;
        check("async_busy",  32'(Busy), 32'h0);
        check("async_ready", 32'({Inst1_Resp.Ready, Inst2_Resp.Ready}), 32'h0);
        check("async_inst",  Inst1_Resp.Inst | Inst2_Resp.Inst, 32'h0);
        idle(2);
        @(negedge Clk);
        #1;
        Rst = 1'b1;
        idle(6);

        // Random traffic, concentrated on a few words to collide with preloads.
        repeat (3000) begin
            automatic bit          r1 = ($urandom_range(0, 2) != 0);
            automatic bit          r2 = ($urandom_range(0, 1) != 0);
            automatic logic [31:0] a1 = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3F);
            automatic logic [31:0] a2 = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3F);
            automatic bit          we = ($urandom_range(0, 3) == 0);
            cyc(r1, a1, r2, a2, we, $urandom & 32'h3F, $urandom);
        end
        idle(LAT + 4);
        check("drain", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
